level_detector: RTL and testbench
=================================

Name: level_detector

Overview:
- Upstream feeder for the neopixel bar controller in the VU-meter chain.
- Takes signed audio samples with a data-valid strobe and tracks a peak envelope with instant attack and exponential decay.
- At a fixed frame rate, maps the envelope linearly to a LED count 0..LEDS.
- Presents the LED count on o_value and issues a single-cycle o_send pulse only when the controller reports ready.

Parameters:
- SW, 16, sample width in bits (signed two's complement).
- LEDS, 20, number of LEDs in the bar; full-scale o_value; must be ≤ 255.
- DECAY_SHIFT, 4, decay step = env >> DECAY_SHIFT.
- DECAY_DIV, 48, number of accepted samples between decay steps.
- UPDATE_CYCLES, 200000, clock cycles per display frame (60 Hz at 12 MHz).

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_sample  in  SW  signed audio sample.
- i_sample_dv  in  1  one-cycle strobe; i_sample valid.
- i_npxl_rdy  in  1  downstream controller idle and able to accept a send.
- o_value  out  8  LED count 0..LEDS; stable from latch until the next frame latch.
- o_send  out  1  one-cycle pulse; controller latches o_value on it.

Behaviour:
- Clock and reset:
  - One clock: i_clk.
  - Reset is asynchronous and active-low (i_rst_n). Assertion at any time, including mid-frame or in WAIT_RDY, immediately clears all state.
- Reset values: env=0, decay_cnt=0, frame_cnt=0, state=IDLE, o_value=0, o_send=0.
- Absolute value:
  - abs = |i_sample| as SW-bit unsigned. Range 0..2^(SW-1).
  - -2^(SW-1) maps to 2^(SW-1) exactly, with no overflow.
- Envelope (SW-bit unsigned, updated only on cycles with i_sample_dv=1):
  - If abs > env: env <= abs (attack takes priority; decay_cnt still advances).
  - Else, if decay_cnt == DECAY_DIV-1: env <= env - max(env>>DECAY_SHIFT, 1) when env>0, so env always reaches 0. env stays 0 when already 0.
  - decay_cnt increments on every dv and wraps from DECAY_DIV-1 to 0.
- Frame counter:
  - frame_cnt counts 0..UPDATE_CYCLES-1 on every clock and wraps.
  - tick = (frame_cnt == UPDATE_CYCLES-1).
- Mapping on tick:
  - level = (env_q * LEDS) >> (SW-1), computed at SW+8 bits.
  - Result is clamped to LEDS.
  - env_q is the registered env before any update in the same cycle, i.e. a simultaneous dv does not affect this frame.
- FSM:
  - IDLE: on tick, o_value <= level, go to WAIT_RDY.
  - WAIT_RDY: if i_npxl_rdy=1, o_send <= 1 for exactly one cycle, go to IDLE. A tick while in WAIT_RDY overwrites o_value with the newer level and stays in WAIT_RDY (no queueing, at most one pending send).
  - Tick and i_npxl_rdy in the same WAIT_RDY cycle: o_value takes the new level and the send fires in that same cycle.
- Latency: o_send rises at the earliest 1 cycle after the tick cycle. o_value is valid no later than the cycle o_send is high.
- o_send is never high for two consecutive cycles.

Decomposition:
- Shared package vu_pkg holds: default SW, default LEDS, and the FSM state encodings (IDLE, WAIT_RDY).
- One sub-module is natural: level_envelope (abs, attack/decay, decay_cnt; outputs env).
- level_detector keeps the frame counter, mapping, and send FSM.

Test Plan:
- Reset mid-WAIT_RDY (i_npxl_rdy held 0, then i_rst_n low) -> o_value=0, o_send=0, state IDLE; no send after release until the next tick.
- UPDATE_CYCLES=100, single dv sample=16384, i_npxl_rdy=1 -> at the next tick o_value=10, one o_send pulse one cycle later.
- Sample=-32768, then 32767 -> o_value=20 at the next frame (no overflow, 32767 does not replace the larger env).
- env=1600, DECAY_DIV=48, then 48 dv samples of 0 -> env=1500; continued zeros drive env to 0 and o_value to 0, including the sub-16 region via minus-1 steps.
- i_npxl_rdy=0 across two ticks with levels 5 then 12, then rdy=1 -> exactly one o_send with o_value=12.
- Tick coincident with dv of 32767 while env=0 -> that frame's o_value=0; the next frame's o_value=19.

Source files
------------

// File: rtl/vu_pkg.sv
// Shared definitions for the VU-meter chain: default geometry and the
// send-FSM state encoding used by level_detector.
package vu_pkg;

    localparam int SW_DEF   = 16;
    localparam int LEDS_DEF = 20;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_RDY = 1'b1
    } state_t;

endpackage

// File: rtl/level_envelope.sv
// Peak envelope follower: instant attack on |sample|, exponential decay
// applied once every DECAY_DIV accepted samples.
module level_envelope
    import vu_pkg::*;
#(
    parameter int SW          = SW_DEF,
    parameter int DECAY_SHIFT = 4,
    parameter int DECAY_DIV   = 48
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [SW-1:0] i_sample,
    input  logic          i_sample_dv,
    output logic [SW-1:0] env
);

    localparam int CW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DECAY_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [SW-1:0] ENV_ONE  = SW'(1);
    localparam logic [SW-1:0] ENV_ZERO = SW'(0);

    logic [SW-1:0] env_r;
    logic [CW-1:0] decay_cnt_r;
    logic [SW-1:0] abs_s;
    logic [SW-1:0] step_s;
    logic [SW-1:0] decayed_s;

    // Magnitude and decay step; -2^(SW-1) negates to itself, which is 2^(SW-1) unsigned.
    always_comb begin
        abs_s     = ENV_ZERO;
        step_s    = ENV_ONE;
        decayed_s = env_r;
        if (i_sample[SW-1]) begin
            abs_s = ~i_sample + ENV_ONE;
        end else begin
            abs_s = i_sample;
        end
        if ((env_r >> DECAY_SHIFT) == ENV_ZERO) begin
            step_s = ENV_ONE;
        end else begin
            step_s = env_r >> DECAY_SHIFT;
        end
        decayed_s = env_r - step_s;
    end

    // Envelope and decay divider, both advanced only on accepted samples.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            env_r       <= ENV_ZERO;
            decay_cnt_r <= '0;
        end else if (i_sample_dv) begin
            if (decay_cnt_r == CNT_LAST) begin
                decay_cnt_r <= '0;
            end else begin
                decay_cnt_r <= decay_cnt_r + CNT_ONE;
            end
            if (abs_s > env_r) begin
                env_r <= abs_s;
            end else if ((decay_cnt_r == CNT_LAST) && (env_r != ENV_ZERO)) begin
                env_r <= decayed_s;
            end else begin
                env_r <= env_r;
            end
        end else begin
            env_r       <= env_r;
            decay_cnt_r <= decay_cnt_r;
        end
    end

    assign env = env_r;

endmodule

// File: rtl/level_detector.sv
// Audio level meter front end: envelope -> per-frame LED count -> one-shot
// send handshake towards the neopixel bar controller.
module level_detector
    import vu_pkg::*;
#(
    parameter int SW            = SW_DEF,
    parameter int LEDS          = LEDS_DEF,
    parameter int DECAY_SHIFT   = 4,
    parameter int DECAY_DIV     = 48,
    parameter int UPDATE_CYCLES = 200000
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [SW-1:0] i_sample,
    input  logic          i_sample_dv,
    input  logic          i_npxl_rdy,
    output logic [7:0]    o_value,
    output logic          o_send
);

    localparam int FW = (UPDATE_CYCLES > 1) ? $clog2(UPDATE_CYCLES) : 1;
    localparam int PW = SW + 8;
    localparam logic [FW-1:0] FRAME_LAST = FW'(UPDATE_CYCLES - 1);
    localparam logic [FW-1:0] FRAME_ONE  = FW'(1);
    localparam logic [PW-1:0] LEDS_W     = PW'(LEDS);
    localparam logic [7:0]    LEDS_8     = 8'(LEDS);

    logic [SW-1:0] env_s;
    logic [FW-1:0] frame_cnt_r;
    logic          tick_s;
    logic [PW-1:0] prod_s;
    logic [PW-1:0] lvl_raw_s;
    logic [7:0]    level_s;
    state_t        state_r;
    state_t        state_nxt_s;
    logic [7:0]    value_r;
    logic [7:0]    value_nxt_s;
    logic          send_r;
    logic          send_nxt_s;

    level_envelope #(
        .SW          (SW),
        .DECAY_SHIFT (DECAY_SHIFT),
        .DECAY_DIV   (DECAY_DIV)
    ) u_env (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_sample    (i_sample),
        .i_sample_dv (i_sample_dv),
        .env         (env_s)
    );

    // Free-running frame counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frame_cnt_r <= '0;
        end else if (tick_s) begin
            frame_cnt_r <= '0;
        end else begin
            frame_cnt_r <= frame_cnt_r + FRAME_ONE;
        end
    end

    assign tick_s = (frame_cnt_r == FRAME_LAST);

    // Linear envelope-to-LED mapping from the registered envelope, clamped to full scale.
    always_comb begin
        prod_s    = {8'd0, env_s} * LEDS_W;
        lvl_raw_s = prod_s >> (SW - 1);
        if (lvl_raw_s > LEDS_W) begin
            level_s = LEDS_8;
        end else begin
            level_s = lvl_raw_s[7:0];
        end
    end

    // Send FSM: latch on tick, fire once the controller is ready; newer ticks overwrite.
    always_comb begin
        state_nxt_s = state_r;
        value_nxt_s = value_r;
        send_nxt_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (tick_s) begin
                    value_nxt_s = level_s;
                    state_nxt_s = WAIT_RDY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT_RDY: begin
                if (tick_s) begin
                    value_nxt_s = level_s;
                end else begin
                    value_nxt_s = value_r;
                end
                if (i_npxl_rdy) begin
                    send_nxt_s  = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT_RDY;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= IDLE;
            value_r <= 8'd0;
            send_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            value_r <= value_nxt_s;
            send_r  <= send_nxt_s;
        end
    end

    assign o_value = value_r;
    assign o_send  = send_r;

endmodule

// File: tb/tb_level_detector.sv
// Directed scoreboard bench for level_detector with a short frame period.
module tb_level_detector;

    localparam int UC = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] sample = 16'd0;
    logic        dv = 1'b0;
    logic        rdy = 1'b0;
    logic [7:0]  value;
    logic        send;

    int vectors = 0;
    int miscompares = 0;
    int exp_q[$];
    int cyc = 0;
    int last_send_cyc = -1;
    int rel_cyc = 0;

    always #5 clk = ~clk;

    level_detector #(
        .SW            (16),
        .LEDS          (20),
        .DECAY_SHIFT   (4),
        .DECAY_DIV     (48),
        .UPDATE_CYCLES (UC)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_sample    (sample),
        .i_sample_dv (dv),
        .i_npxl_rdy  (rdy),
        .o_value     (value),
        .o_send      (send)
    );

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops an expectation on every send pulse.
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n && send) begin
                last_send_cyc = cyc;
                check("send_not_consecutive", int'(prev), 0);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_send: o_value=%0d with no send expected", value);
                end else begin
                    check("send_value", int'(value), exp_q.pop_front());
                end
            end
            prev = rst_n ? send : 1'b0;
        end
    end

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        dv = 1'b0;
        rdy = 1'b0;
        sample = 16'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rel_cyc = cyc;
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic dv_send(input logic [15:0] s);
        sample = s;
        dv = 1'b1;
        @(negedge clk);
        dv = 1'b0;
    endtask

    task automatic dv_zeros(input int n);
        for (int i = 0; i < n; i++) dv_send(16'd0);
    endtask

    task automatic drain(input string name, input int max_cyc);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        rdy = 1'b0;
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: %0d sends still pending after %0d cycles", name, exp_q.size(), max_cyc);
            exp_q.delete();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish, %0d vectors applied", vectors);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset clears a pending send asynchronously.
        reset_dut();
        check("reset_value", int'(value), 0);
        check("reset_send", int'(send), 0);
        dv_send(16'd16384);
        wait_neg(104);
        check("pending_value", int'(value), 10);
        rst_n = 1'b0;
        #1;
        check("async_rst_value", int'(value), 0);
        check("async_rst_send", int'(send), 0);
        wait_neg(2);
        rdy = 1'b1;
        rst_n = 1'b1;
        rel_cyc = cyc;
        wait_neg(50);
        exp_q.push_back(0);
        drain("post_reset_send", 70);

        // Half scale: level 10, one send shortly after the tick.
        reset_dut();
        rdy = 1'b1;
        dv_send(16'd16384);
        exp_q.push_back(10);
        drain("half_scale", 120);
        check("send_latency_ok", int'((last_send_cyc - rel_cyc) >= 100 && (last_send_cyc - rel_cyc) <= 102), 1);

        // Most negative sample is full scale; a smaller positive peak does not replace it.
        reset_dut();
        dv_send(16'h8000);
        dv_send(16'h7FFF);
        exp_q.push_back(20);
        rdy = 1'b1;
        drain("full_scale", 120);

        // One decay step from 16384 is visible on the bar.
        reset_dut();
        dv_send(16'd16384);
        dv_zeros(48);
        exp_q.push_back(9);
        rdy = 1'b1;
        drain("decayed_level", 120);

        // Decay arithmetic down to zero.
        reset_dut();
        dv_send(16'd1600);
        dv_zeros(48);
        check("env_after_one_step", int'(dut.env_s), 1500);
        dv_zeros(48);
        check("env_after_two_steps", int'(dut.env_s), 1407);
        dv_zeros(4800);
        check("env_decays_to_zero", int'(dut.env_s), 0);
        exp_q.push_back(0);
        rdy = 1'b1;
        drain("decayed_zero", 150);

        // Sub-16 envelope decays by one per step.
        reset_dut();
        dv_send(16'd15);
        dv_zeros(48);
        check("env_small_minus_one", int'(dut.env_s), 14);
        dv_zeros(48 * 14);
        check("env_small_to_zero", int'(dut.env_s), 0);
        dv_zeros(48);
        check("env_stays_zero", int'(dut.env_s), 0);

        // Two ticks while not ready: only the newer level is sent, once.
        reset_dut();
        dv_send(16'd8192);
        wait_neg(120);
        check("first_tick_level", int'(value), 5);
        dv_send(16'd20000);
        wait_neg(99);
        check("second_tick_level", int'(value), 12);
        exp_q.push_back(12);
        rdy = 1'b1;
        drain("overwrite_send", 10);
        rdy = 1'b1;
        wait_neg(20);
        rdy = 1'b0;

        // Sample arriving on the tick edge belongs to the next frame.
        reset_dut();
        wait_neg(99);
        dv_send(16'd32767);
        check("tick_dv_value", int'(value), 0);
        exp_q.push_back(0);
        rdy = 1'b1;
        drain("tick_dv_send", 10);
        exp_q.push_back(19);
        rdy = 1'b1;
        drain("next_frame_send", 120);

        wait_neg(5);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
